mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_pick.sv | 45 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D-cache memory arbiter.
// Optional feature macro: ARB_RR_EN (round-robin arbitration).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int ADDR_WIDTH_DEF  = 16;
    localparam int BLOCK_WORDS_DEF = 8;
    localparam int MEM_LAT_DEF     = 4;

    // Requester that wins a tie under round-robin.
    function automatic owner_e rr_winner(input owner_e last);
        return (last == OWN_D) ? OWN_I : OWN_D;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-requester grant logic; D over I, or round-robin when ARB_RR_EN is defined.
// Macro: ARB_RR_EN.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic   clk,
    input  logic   rst,
`endif
    input  logic   en_i,
    input  logic   i_req_i,
    input  logic   d_req_i,
    output logic   gnt_o,
    output owner_e own_o
);

    assign gnt_o = en_i & (i_req_i | d_req_i);

`ifdef ARB_RR_EN
    owner_e last_q;

    always_comb begin
        own_o = OWN_D;
        if (i_req_i && d_req_i) begin
            own_o = rr_winner(last_q);
        end else if (i_req_i) begin
            own_o = OWN_I;
        end
    end

    // Reset to OWN_I so the first contest after reset goes to D.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_I;
        end else if (gnt_o) begin
            last_q <= own_o;
        end
    end
`else
    always_comb begin
        own_o = d_req_i ? OWN_D : OWN_I;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache block fills and D-cache fills/writes onto one memory port.
// Macro ARB_RR_EN selects round-robin instead of fixed D-over-I priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int MEM_LAT     = MEM_LAT_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req,
    input  logic [ADDR_WIDTH-1:0]          i_addr,
    input  logic                           d_req,
    input  logic                           d_wr,
    input  logic [ADDR_WIDTH-1:0]          d_addr,
    input  logic [15:0]                    d_wdata,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
    output logic                           i_fill_vld,
    output logic                           d_fill_vld,
    output logic                           i_done,
    output logic                           d_done,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [15:0]                    mem_wdata,
    input  logic [15:0]                    mem_rdata,
    input  logic                           mem_valid
);

    localparam int IDXW = $clog2(BLOCK_WORDS);
    localparam int OFF  = IDXW + 1;
    localparam int BW   = ADDR_WIDTH - OFF;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BLOCK_WORDS - 1);
    localparam bit LAST_IN_ISSUE = (MEM_LAT == 0);

    state_e          state_q;
    owner_e          own_q;
    logic [BW-1:0]   base_q;
    logic [IDXW-1:0] icnt_q;
    logic [IDXW-1:0] icnt_d;
    logic [IDXW-1:0] rcnt_q;
    logic            mem_en_q;
    logic            mem_wr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [15:0]     mem_wdata_q;
    logic            wdone_q;

    logic            gnt;
    owner_e          gnt_own;
    logic [BW-1:0]   gnt_base;
    logic            rtn_act;
    logic            rtn_last;
    logic            unused_i_lsb;

    mem_arb_pick u_pick (
`ifdef ARB_RR_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .en_i    (state_q == IDLE),
        .i_req_i (i_req),
        .d_req_i (d_req),
        .gnt_o   (gnt),
        .own_o   (gnt_own)
    );

    // A fill always starts at word 0, so the byte/word offset is dropped.
    assign unused_i_lsb = ^i_addr[OFF-1:0];
    assign gnt_base = (gnt_own == OWN_D) ? d_addr[ADDR_WIDTH-1:OFF]
                                         : i_addr[ADDR_WIDTH-1:OFF];
    assign icnt_d = icnt_q + 1'b1;

    assign rtn_act = !rst && mem_valid &&
                     (state_q == ISSUE || state_q == DRAIN);
    assign rtn_last = rtn_act && (rcnt_q == LAST_IDX) &&
                      (state_q == DRAIN || LAST_IN_ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            own_q       <= OWN_I;
            base_q      <= '0;
            icnt_q      <= '0;
            rcnt_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wdone_q     <= 1'b0;
        end else begin
            if (rtn_act) begin
                rcnt_q <= rcnt_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (gnt) begin
                        own_q    <= gnt_own;
                        icnt_q   <= '0;
                        rcnt_q   <= '0;
                        mem_en_q <= 1'b1;
                        if (gnt_own == OWN_D && d_wr) begin
                            state_q     <= WRITE;
                            mem_wr_q    <= 1'b1;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                            wdone_q     <= 1'b1;
                        end else begin
                            state_q    <= ISSUE;
                            mem_wr_q   <= 1'b0;
                            base_q     <= gnt_base;
                            mem_addr_q <= {gnt_base, {IDXW{1'b0}}, 1'b0};
                        end
                    end
                end
                ISSUE: begin
                    if (icnt_q == LAST_IDX) begin
                        state_q    <= rtn_last ? IDLE : DRAIN;
                        mem_en_q   <= 1'b0;
                        mem_addr_q <= '0;
                    end else begin
                        icnt_q     <= icnt_d;
                        mem_addr_q <= {base_q, icnt_d, 1'b0};
                    end
                end
                DRAIN: begin
                    if (rtn_last) begin
                        state_q <= IDLE;
                    end
                end
                WRITE: begin
                    state_q     <= IDLE;
                    mem_en_q    <= 1'b0;
                    mem_wr_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    wdone_q     <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fill_data  = rtn_act ? mem_rdata : '0;
    assign fill_idx   = rtn_act ? rcnt_q : '0;
    assign i_fill_vld = rtn_act && (own_q == OWN_I);
    assign d_fill_vld = rtn_act && (own_q == OWN_D);
    assign i_done     = rtn_last && (own_q == OWN_I);
    assign d_done     = (rtn_last && (own_q == OWN_D)) || wdone_q;

    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a fixed-latency memory model.
// Expectations follow ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int BWD = 8;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] fill_data;
    logic [2:0]  fill_idx;
    logic        i_fill_vld, d_fill_vld, i_done, d_done;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        stray = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BWD), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .fill_data(fill_data), .fill_idx(fill_idx),
        .i_fill_vld(i_fill_vld), .d_fill_vld(d_fill_vld),
        .i_done(i_done), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    logic [15:0] mem    [0:32767];
    logic [15:0] shadow [0:32767];
    logic [LAT-1:0] pv;
    logic [15:0] pd [LAT];

    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv <= {pv[LAT-2:0], mem_en & ~mem_wr};
            pd[0] <= mem[mem_addr[15:1]];
            for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
            if (mem_en && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
        end
    end
    assign mem_valid = pv[LAT-1] | stray;
    assign mem_rdata = pd[LAT-1];

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } cmd_t;
    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  idx;
        logic [15:0] data;
    } rsp_t;

    cmd_t cmdq[$];
    rsp_t rspq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   fill_start = 0;
    int   last_done = -100;
    int   i_done_cnt = 0;
    bit   sb_en = 1'b1;
    int   i_left = 0;
    int   d_left = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: DUT output with nothing expected", nm);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (i_done) i_done_cnt++;
        if (sb_en) begin
            if (mem_en) begin
                if (cmdq.size() == 0) begin
                    bad("cmd_unexpected");
                end else begin
                    c = cmdq.pop_front();
                    chk("cmd_wr", {31'b0, mem_wr}, {31'b0, c.wr});
                    chk("cmd_addr", {16'b0, mem_addr}, {16'b0, c.addr});
                    if (c.wr) begin
                        chk("cmd_wdata", {16'b0, mem_wdata}, {16'b0, c.data});
                        chk("wr_done_same_cycle", {31'b0, d_done}, 1);
                    end else if (c.addr[3:0] == 4'h0) begin
                        fill_start = cyc;
                        chk("issue_after_done", {31'b0, (cyc - last_done) >= 2}, 1);
                    end
                end
            end
            if (i_fill_vld || d_fill_vld) begin
                if (rspq.size() == 0) begin
                    bad("fill_unexpected");
                end else begin
                    r = rspq.pop_front();
                    chk("fill_kind", {30'b0, i_fill_vld, d_fill_vld},
                        r.kind[1] ? 32'h0 : (r.kind[0] ? 32'h1 : 32'h2));
                    chk("fill_idx", {29'b0, fill_idx}, {29'b0, r.idx});
                    chk("fill_data", {16'b0, fill_data}, {16'b0, r.data});
                end
            end
            if (i_done || d_done) begin
                if (rspq.size() == 0) begin
                    bad("done_unexpected");
                end else begin
                    r = rspq.pop_front();
                    chk("done_kind", {30'b0, i_done, d_done},
                        !r.kind[1] ? 32'h0 : (r.kind[0] ? 32'h1 : 32'h2));
                    if (!(mem_en && mem_wr)) chk("done_latency", cyc - fill_start, 11);
                    last_done = cyc;
                end
            end
        end
    end

    task automatic push_fill(input logic own, input logic [15:0] a);
        cmd_t c;
        rsp_t r;
        logic [15:0] wa;
        for (int k = 0; k < BWD; k++) begin
            wa = {a[15:4], 3'(k), 1'b0};
            c.wr = 1'b0; c.addr = wa; c.data = '0;
            cmdq.push_back(c);
            r.kind = {1'b0, own}; r.idx = 3'(k); r.data = shadow[wa[15:1]];
            rspq.push_back(r);
        end
        r.kind = {1'b1, own}; r.idx = '0; r.data = '0;
        rspq.push_back(r);
    endtask

    task automatic push_write(input logic [15:0] a, input logic [15:0] d);
        cmd_t c;
        rsp_t r;
        c.wr = 1'b1; c.addr = a; c.data = d;
        cmdq.push_back(c);
        r.kind = 2'b11; r.idx = '0; r.data = '0;
        rspq.push_back(r);
        shadow[a[15:1]] = d;
    endtask

    task automatic run(input string nm);
        int n;
        n = 0;
        while ((i_left > 0 || d_left > 0 || cmdq.size() > 0 || rspq.size() > 0)
               && n < 300) begin
            @(negedge clk);
            n++;
            if (i_done && i_left > 0) begin
                i_left--;
                if (i_left == 0) i_req = 1'b0;
            end
            if (d_done && d_left > 0) begin
                d_left--;
                if (d_left == 0) d_req = 1'b0;
            end
        end
        chk({nm, "_timeout"}, {31'b0, n < 300}, 1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {23'b0, mem_en, mem_wr, fill_idx,
                           i_fill_vld, d_fill_vld, i_done, d_done}, 0);
        chk({nm, "_addr"}, {mem_addr, mem_wdata}, 0);
        chk({nm, "_data"}, {16'b0, fill_data}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        cmdq.delete();
        rspq.delete();
    endtask

    initial begin
        int n0;
        for (int w = 0; w < 32768; w++) begin
            mem[w]    = 16'(w * 2) ^ 16'hC3C3;
            shadow[w] = 16'(w * 2) ^ 16'hC3C3;
        end
        do_reset();

        @(posedge clk);
        #1 stray = 1'b1;
        @(negedge clk);
        chk("idle_valid_ignored", {30'b0, i_fill_vld, d_fill_vld}, 0);
        #1 stray = 1'b0;

        @(negedge clk);
        push_fill(1'b0, 16'h1236);
        i_addr = 16'h1236; i_left = 1; i_req = 1'b1;
        run("i_fill");

        @(negedge clk);
        push_write(16'h0040, 16'hBEEF);
        d_addr = 16'h0040; d_wdata = 16'hBEEF; d_wr = 1'b1;
        d_left = 1; d_req = 1'b1;
        run("d_write");
        @(negedge clk);
        push_fill(1'b1, 16'h0040);
        d_wr = 1'b0; d_left = 1; d_req = 1'b1;
        run("d_fill_after_wr");

        @(negedge clk);
        push_fill(1'b1, 16'h2000);
        push_fill(1'b0, 16'h3010);
        d_addr = 16'h2000; d_left = 1; d_req = 1'b1;
        repeat (4) @(negedge clk);
        i_addr = 16'h3010; i_left = 1; i_req = 1'b1;
        run("i_during_d");

        @(negedge clk);
        sb_en = 1'b0;
        i_addr = 16'h4000; i_req = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1; i_req = 1'b0;
        @(negedge clk);
        chk_zero("rst_mid_fill");
        rst = 1'b0;
        n0 = i_done_cnt;
        repeat (20) @(negedge clk);
        chk("no_done_after_abort", i_done_cnt - n0, 0);
        cmdq.delete();
        rspq.delete();
        sb_en = 1'b1;
        push_fill(1'b0, 16'h4008);
        i_addr = 16'h4008; i_left = 1; i_req = 1'b1;
        run("fresh_after_rst");

        do_reset();
        push_fill(1'b1, 16'h5000);
        push_fill(1'b0, 16'h6000);
        d_addr = 16'h5000; i_addr = 16'h6000; d_wr = 1'b0;
        d_left = 1; i_left = 1; d_req = 1'b1; i_req = 1'b1;
        run("contend");

        @(negedge clk);
`ifdef ARB_RR_EN
        push_fill(1'b1, 16'h7000);
        push_fill(1'b0, 16'h8000);
        push_fill(1'b1, 16'h7000);
`else
        push_fill(1'b1, 16'h7000);
        push_fill(1'b1, 16'h7000);
        push_fill(1'b0, 16'h8000);
`endif
        d_addr = 16'h7000; i_addr = 16'h8000;
        d_left = 2; i_left = 1; d_req = 1'b1; i_req = 1'b1;
        run("contend_repeat");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
